// File: rtl/booth_mult_32x32_pkg.sv
// booth_mult_32x32_pkg: shared state encoding, widths and operand extension for the Booth multiplier
package booth_mult_32x32_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int OP_W = 32;
  localparam int PROD_W = 64;
  localparam int ITERS = 33;
  localparam int CNT_W = 6;
  function automatic logic [OP_W:0] ext33(input logic [OP_W-1:0] v, input logic sgn);
    return {sgn & v[OP_W-1], v};
  endfunction
endpackage

// File: rtl/booth_mult_32x32_if.sv
// booth_mult_32x32_if: operand/product handshake bundle; is_signed exists only with BOOTH_UNSIGNED_EN
interface booth_mult_32x32_if;
  import booth_mult_32x32_pkg::*;
  logic in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [OP_W-1:0] a, b;
  logic [PROD_W-1:0] product;
`ifdef BOOTH_UNSIGNED_EN
  logic is_signed;
`endif
  modport master (
`ifdef BOOTH_UNSIGNED_EN
    output is_signed,
`endif
    output in_valid, a, b, out_ready,
    input in_ready, out_valid, product, zero, busy
  );
  modport slave (
`ifdef BOOTH_UNSIGNED_EN
    input is_signed,
`endif
    input in_valid, a, b, out_ready,
    output in_ready, out_valid, product, zero, busy
  );
endinterface

// File: rtl/booth_mult_32x32_addsub.sv
// adder_subtractor_64bit: two's-complement add (s=0) or subtract (s=1)
module adder_subtractor_64bit import booth_mult_32x32_pkg::*; (
  input  logic [PROD_W-1:0] a,
  input  logic [PROD_W-1:0] b,
  input  logic              s,
  output logic [PROD_W-1:0] sum
);
  assign sum = a + (b ^ {PROD_W{s}}) + PROD_W'(s);
endmodule

// File: rtl/booth_mult_32x32.sv
// booth_mult_32x32: sequential radix-2 Booth multiplier, 33 steps per product.
// Define BOOTH_UNSIGNED_EN to add the is_signed operand-mode select.
module booth_mult_32x32 import booth_mult_32x32_pkg::*; (
  input logic clk,
  input logic rst,
  booth_mult_32x32_if.slave bus
);
  state_t state, next;
  logic [OP_W+1:0] acc, acc_n;
  logic [OP_W:0] m, q;
  logic q_m1, sgn, accept, last, done;
  logic [CNT_W-1:0] cnt;
  logic [PROD_W-1:0] sum, prod;
  logic [PROD_W-OP_W-3:0] unused_hi;
`ifdef BOOTH_UNSIGNED_EN
  assign sgn = bus.is_signed;
`else
  assign sgn = 1'b1;
`endif
  assign accept = bus.in_valid && state == IDLE;
  assign last = cnt == CNT_W'(ITERS - 1);
  assign done = state == DONE;
  // {Q[0],q_m1} = 10 subtracts, 01 adds; the adder output is only used when they differ
  adder_subtractor_64bit u_addsub (
    .a({{(PROD_W-OP_W-2){acc[OP_W+1]}}, acc}),
    .b({{(PROD_W-OP_W-1){m[OP_W]}}, m}),
    .s(q[0]),
    .sum(sum)
  );
  assign unused_hi = sum[PROD_W-1:OP_W+2];
  assign acc_n = (q[0] ^ q_m1) ? sum[OP_W+1:0] : acc;
  // {acc,q} is a 67-bit signed product; its low 64 bits are the result
  assign prod = {acc[PROD_W-OP_W-2:0], q};
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE ? (bus.in_valid ? RUN : IDLE) :
           state == RUN  ? (last ? DONE : RUN) :
           state == DONE ? (bus.out_ready ? IDLE : DONE) : IDLE;
  always_comb begin
    bus.in_ready = state == IDLE;
    bus.out_valid = done;
    bus.busy = state != IDLE;
    bus.product = done ? prod : '0;
    bus.zero = done && prod == '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      m <= '0;
      q <= '0;
      q_m1 <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      acc <= '0;
      m <= ext33(bus.a, sgn);
      q <= ext33(bus.b, sgn);
      q_m1 <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      {acc, q, q_m1} <= {acc_n[OP_W+1], acc_n, q};
      cnt <= cnt + 1'b1;
    end
endmodule
